datapath_core_param: RTL

Parametrised successor to the fixed 16-bit CPU datapath. It holds a WIDTH-bit, NREG-entry register file and two read buses (A, B) feeding a single result bus S. Both operands are register-selectable, so B is no longer hard-wired to one register. It adds an integrated ALU/shifter with NZVC flag generation, an iterative sequential multiplier, and a req/ack memory handshake on MAR/MDR. The block sits between the microcode sequencer, which drives the encoded controls, and the memory subsystem.

---
 rtl/datapath_core_param.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_core_param.sv
// Purpose: parametrised CPU datapath: register file, A/B/S buses, ALU/shifter with NZVC, shift-add multiplier, MAR/MDR memory port.
// Latency: S bus combinational; reg/MAR/MDR/PSW 1 cycle; memory >=2 cycles (req the cycle after start); multiply WIDTH cycles.
// Backpressure: memory holds req until mem_ack and ignores new starts / MAR / MDR writes meanwhile; mul_start ignored while busy.
module datapath_core_param #(
    parameter  int WIDTH = 16,
    parameter  int NREG  = 8,
    localparam int RW    = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [1:0]       a_src,
    input  logic [RW-1:0]    a_sel,
    input  logic [RW-1:0]    b_sel,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] imm,
    input  logic             s_we,
    input  logic [RW-1:0]    s_sel,
    input  logic             flag_we,
    input  logic             mar_we,
    input  logic             mdr_we,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             mul_start,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_busy,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [3:0]       psw,
    output logic [WIDTH-1:0] s_bus
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND  = 4'd3,
        OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_LSL = 4'd6,  OP_LSR  = 4'd7,
        OP_ASR  = 4'd8,  OP_ROL = 4'd9,  OP_ROR = 4'd10, OP_MULL = 4'd11,
        OP_MULH = 4'd12, OP_IMM = 4'd13, OP_R14 = 4'd14, OP_R15  = 4'd15
    } op_e;

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} mem_st_e;

    // architectural state
    logic [WIDTH-1:0]   r_regs [NREG];
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_prod_lo;
    logic [WIDTH-1:0]   r_prod_hi;
    logic [3:0]         r_psw;

    // memory handshake
    mem_st_e            r_mem_st;
    mem_st_e            w_mem_st_nxt;
    logic               r_mem_we;
    logic               w_mem_idle;

    // multiplier: acc holds {partial product, remaining multiplier bits}
    logic               r_mul_busy;
    logic               r_mul_done;
    logic [WIDTH-1:0]   r_mul_mc;
    logic [2*WIDTH-1:0] r_mul_acc;
    logic [CW-1:0]      r_mul_cnt;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc_nxt;

    // buses and ALU
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_s;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic               w_n;
    logic               w_z;
    logic               w_v;
    logic               w_c;

    assign w_mem_idle = (r_mem_st == ST_IDLE);

    // A bus source select; B always reads the register file
    always_comb begin
        w_a = '0;
        case (a_src)
            2'd0:    w_a = r_regs[a_sel];
            2'd1:    w_a = r_mdr;
            2'd2:    w_a = {{(WIDTH-4){1'b0}}, r_psw};
            default: w_a = '0;
        endcase
        w_b = r_regs[b_sel];
    end

    // the MSB of the extended results is carry out / borrow
    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub = {1'b0, w_a} - {1'b0, w_b};

    // ALU / shifter result and V/C; ops that do not define C keep the old one
    always_comb begin
        w_s = '0;
        w_c = r_psw[0];
        w_v = 1'b0;
        case (op_e'(op))
            OP_PASS: w_s = w_a;
            OP_ADD: begin
                w_s = w_add[MSB:0];
                w_c = w_add[WIDTH];
                w_v = (w_a[MSB] == w_b[MSB]) && (w_add[MSB] != w_a[MSB]);
            end
            OP_SUB: begin
                w_s = w_sub[MSB:0];
                w_c = w_sub[WIDTH];
                w_v = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);
            end
            OP_AND:  w_s = w_a & w_b;
            OP_OR:   w_s = w_a | w_b;
            OP_XOR:  w_s = w_a ^ w_b;
            OP_LSL: begin
                w_s = {w_a[MSB-1:0], 1'b0};
                w_c = w_a[MSB];
            end
            OP_LSR: begin
                w_s = {1'b0, w_a[MSB:1]};
                w_c = w_a[0];
            end
            OP_ASR: begin
                w_s = {w_a[MSB], w_a[MSB:1]};
                w_c = w_a[0];
            end
            OP_ROL: begin
                w_s = {w_a[MSB-1:0], w_a[MSB]};
                w_c = w_a[MSB];
            end
            OP_ROR: begin
                w_s = {w_a[0], w_a[MSB:1]};
                w_c = w_a[0];
            end
            OP_MULL: w_s = r_prod_lo;
            OP_MULH: w_s = r_prod_hi;
            OP_IMM:  w_s = imm;
            default: w_s = '0;
        endcase
        w_n = w_s[MSB];
        w_z = (w_s == '0);
    end

    // register file write from the S bus
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (s_we) begin
            r_regs[s_sel] <= w_s;
        end
    end

    // status word update
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_psw <= '0;
        end else if (flag_we) begin
            r_psw <= {w_n, w_z, w_v, w_c};
        end
    end

    // MAR/MDR: frozen during a request so address and write data stay stable
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_mar <= '0;
            r_mdr <= '0;
        end else if (w_mem_idle) begin
            if (mar_we) r_mar <= w_s;
            if (mdr_we) r_mdr <= w_s;
        end else if (mem_ack && !r_mem_we) begin
            r_mdr <= mem_rdata;
        end
    end

    // memory FSM state register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_mem_st <= ST_IDLE;
        end else begin
            r_mem_st <= w_mem_st_nxt;
        end
    end

    // memory FSM next state
    always_comb begin
        w_mem_st_nxt = r_mem_st;
        case (r_mem_st)
            ST_IDLE: if (mem_rd || mem_wr) w_mem_st_nxt = ST_REQ;
            ST_REQ:  if (mem_ack)          w_mem_st_nxt = ST_IDLE;
            default: w_mem_st_nxt = ST_IDLE;
        endcase
    end

    // transaction direction, latched at start; a write wins over a read
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_mem_we <= 1'b0;
        end else if (w_mem_idle && (mem_rd || mem_wr)) begin
            r_mem_we <= mem_wr;
        end else if (!w_mem_idle && mem_ack) begin
            r_mem_we <= 1'b0;
        end
    end

    // one shift-add step: add multiplicand to the upper half if LSB set, then shift right
    always_comb begin
        w_mul_sum     = {1'b0, r_mul_acc[2*WIDTH-1:WIDTH]}
                      + (r_mul_acc[0] ? {1'b0, r_mul_mc} : {(WIDTH+1){1'b0}});
        w_mul_acc_nxt = {w_mul_sum, r_mul_acc[WIDTH-1:1]};
    end

    // multiplier sequencing; product registers only change when a multiply completes
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_mul_busy <= 1'b0;
            r_mul_done <= 1'b0;
            r_mul_mc   <= '0;
            r_mul_acc  <= '0;
            r_mul_cnt  <= '0;
            r_prod_lo  <= '0;
            r_prod_hi  <= '0;
        end else begin
            r_mul_done <= 1'b0;
            if (r_mul_busy) begin
                r_mul_acc <= w_mul_acc_nxt;
                r_mul_cnt <= r_mul_cnt - CW'(1);
                if (r_mul_cnt == CW'(1)) begin
                    r_mul_busy <= 1'b0;
                    r_mul_done <= 1'b1;
                    r_prod_lo  <= w_mul_acc_nxt[WIDTH-1:0];
                    r_prod_hi  <= w_mul_acc_nxt[2*WIDTH-1:WIDTH];
                end
            end else if (mul_start) begin
                r_mul_busy <= 1'b1;
                r_mul_mc   <= w_a;
                r_mul_acc  <= {{WIDTH{1'b0}}, w_b};
                r_mul_cnt  <= CW'(WIDTH);
            end
        end
    end

    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign mem_req   = (r_mem_st == ST_REQ);
    assign mem_busy  = mem_req;
    assign mem_we    = r_mem_we;
    assign mul_busy  = r_mul_busy;
    assign mul_done  = r_mul_done;
    assign psw       = r_psw;
    assign s_bus     = w_s;

endmodule
